// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer engine: FSM encoding,
// constant-width log2 and the requantise/saturate/ReLU step.
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fc_state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Round-half-up arithmetic shift, clamp to a signed data_w range, optional ReLU.
  function automatic logic signed [63:0] requant(input logic signed [63:0] t,
                                                 input int shift,
                                                 input int data_w,
                                                 input logic relu);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = t;
    if (shift > 0) r = (t + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    if (relu && (r < 0)) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/fc_layer_param_if.sv
// Memory, multiplier-array and result-write bundle of the FC engine.
// master = engine side, slave = RAM / multiplier / next-layer side.
interface fc_layer_param_if #(
  parameter int GA_W       = 1,
  parameter int WA_W       = 3,
  parameter int CA_W       = 2,
  parameter int GROUP_SIZE = 32,
  parameter int DATA_W     = 8
);
  logic [GA_W-1:0]                in_addr;
  logic [GROUP_SIZE*DATA_W-1:0]   input_data;
  logic [WA_W-1:0]                weight_addr;
  logic [GROUP_SIZE*DATA_W-1:0]   weight;
  logic [CA_W-1:0]                bias_addr;
  logic [DATA_W-1:0]              bias;
  logic [GROUP_SIZE*DATA_W-1:0]   mul_data1;
  logic [GROUP_SIZE*DATA_W-1:0]   mul_data2;
  logic [GROUP_SIZE*2*DATA_W-1:0] mul_result;
  logic                           fc_output_wren;
  logic [CA_W-1:0]                fc_output_addr;
  logic [DATA_W-1:0]              fc_output_data;

  modport master (
    output in_addr, weight_addr, bias_addr, mul_data1, mul_data2,
           fc_output_wren, fc_output_addr, fc_output_data,
    input  input_data, weight, bias, mul_result
  );

  modport slave (
    input  in_addr, weight_addr, bias_addr, mul_data1, mul_data2,
           fc_output_wren, fc_output_addr, fc_output_data,
    output input_data, weight, bias, mul_result
  );
endinterface

// File: rtl/fc_adder_tree.sv
// Pipelined signed adder tree, N inputs of IN_W bits, one register per level.
// Latency clog2(N) cycles; no backpressure, accepts one vector every cycle.
module fc_adder_tree
  import fc_pkg::*;
#(
  parameter int N    = 32,
  parameter int IN_W = 16,
  localparam int LAT = clog2(N)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [N*IN_W-1:0]     in_dat,
  output logic [IN_W+LAT-1:0]   sum_dat
);

  // Level l holds N>>(l+1) partial sums, each one bit wider than its operands.
  for (genvar l = 0; l < LAT; l++) begin : g_lvl
    localparam int CNT = N >> (l + 1);
    localparam int W   = IN_W + l + 1;
    logic [2*CNT*(W-1)-1:0] src;
    logic [CNT*W-1:0]       sum_q;

    if (l == 0) begin : g_first
      assign src = in_dat;
    end else begin : g_next
      assign src = g_lvl[l-1].sum_q;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        sum_q <= '0;
      end else begin
        for (int i = 0; i < CNT; i++) begin
          sum_q[i*W +: W] <= W'($signed(src[(2*i)*(W-1) +: W-1]))
                           + W'($signed(src[(2*i+1)*(W-1) +: W-1]));
        end
      end
    end
  end

  if (LAT == 0) begin : g_pass
    assign sum_dat = in_dat;
  end else begin : g_out
    assign sum_dat = g_lvl[LAT-1].sum_q;
  end

endmodule

// File: rtl/fc_layer_param.sv
// FC layer: OUTPUT_DIM dot products over INPUT_DIM inputs, GROUP_SIZE per cycle, bias + requant + ReLU.
// First write NG+MUL_LAT+ADD_LAT+3 cycles after start, then one per NG cycles; no backpressure.
module fc_layer_param
  import fc_pkg::*;
#(
  parameter int INPUT_DIM  = 64,
  parameter int OUTPUT_DIM = 4,
  parameter int GROUP_SIZE = 32,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 24,
  parameter int MUL_LAT    = 1,
  parameter int OUT_SHIFT  = 9,
  parameter int BIAS_SHIFT = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              relu_en_i,
  output logic              busy_o,
  output logic              done_o,
  fc_layer_param_if.master  bus
);

  localparam int NG      = INPUT_DIM / GROUP_SIZE;
  localparam int GA_W    = max1(clog2(NG));
  localparam int CA_W    = max1(clog2(OUTPUT_DIM));
  localparam int WA_W    = max1(clog2(NG * OUTPUT_DIM));
  localparam int ADD_LAT = clog2(GROUP_SIZE);
  localparam int SUM_W   = 2 * DATA_W + ADD_LAT;
  localparam int PIPE_D  = 1 + MUL_LAT + ADD_LAT;
  localparam int L       = PIPE_D - 1;
  localparam logic [GA_W-1:0] G_LAST = GA_W'(NG - 1);
  localparam logic [CA_W-1:0] C_LAST = CA_W'(OUTPUT_DIM - 1);

  fc_state_e       state_q, state_d;
  logic [GA_W-1:0] g_q;
  logic [CA_W-1:0] ch_q;
  logic            relu_q;
  logic            issue_last;
  logic            wr_vld_q;
  logic [CA_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_dat_q;

  assign issue_last = (g_q == G_LAST) && (ch_q == C_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_ISSUE;
      ST_ISSUE: if (issue_last) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_vld_q && (wr_addr_q == C_LAST)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);

  // Group index runs fastest so each channel's groups issue back to back.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      g_q    <= '0;
      ch_q   <= '0;
      relu_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && start_i) begin
      g_q    <= '0;
      ch_q   <= '0;
      relu_q <= relu_en_i;
    end else if (state_q == ST_ISSUE) begin
      if (g_q == G_LAST) begin
        g_q  <= '0;
        ch_q <= (ch_q == C_LAST) ? '0 : ch_q + CA_W'(1);
      end else begin
        g_q <= g_q + GA_W'(1);
      end
    end
  end

  assign bus.in_addr     = g_q;
  assign bus.bias_addr   = ch_q;
  assign bus.weight_addr = WA_W'(ch_q) * WA_W'(NG) + WA_W'(g_q);
  assign bus.mul_data1   = bus.input_data;
  assign bus.mul_data2   = bus.weight;

  logic [SUM_W-1:0] tree_sum;

  fc_adder_tree #(
    .N    (GROUP_SIZE),
    .IN_W (2 * DATA_W)
  ) u_tree (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .in_dat  (bus.mul_result),
    .sum_dat (tree_sum)
  );

  // Tag rides alongside the RAM read, multiplier and tree; bias joins one stage in,
  // when the registered bias RAM output lines up with its request.
  logic                     tag_vld_q   [PIPE_D];
  logic                     tag_first_q [PIPE_D];
  logic                     tag_last_q  [PIPE_D];
  logic [CA_W-1:0]          tag_ch_q    [PIPE_D];
  logic signed [DATA_W-1:0] bias_pipe_q [PIPE_D-1];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < PIPE_D; i++) begin
        tag_vld_q[i]   <= 1'b0;
        tag_first_q[i] <= 1'b0;
        tag_last_q[i]  <= 1'b0;
        tag_ch_q[i]    <= '0;
      end
      for (int i = 0; i < PIPE_D - 1; i++) bias_pipe_q[i] <= '0;
    end else begin
      tag_vld_q[0]   <= (state_q == ST_ISSUE);
      tag_first_q[0] <= (g_q == '0);
      tag_last_q[0]  <= (g_q == G_LAST);
      tag_ch_q[0]    <= ch_q;
      bias_pipe_q[0] <= $signed(bus.bias);
      for (int i = 1; i < PIPE_D; i++) begin
        tag_vld_q[i]   <= tag_vld_q[i-1];
        tag_first_q[i] <= tag_first_q[i-1];
        tag_last_q[i]  <= tag_last_q[i-1];
        tag_ch_q[i]    <= tag_ch_q[i-1];
      end
      for (int i = 1; i < PIPE_D - 1; i++) bias_pipe_q[i] <= bias_pipe_q[i-1];
    end
  end

  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  sum_ext;
  logic                     post_vld_q;
  logic [CA_W-1:0]          post_ch_q;
  logic signed [DATA_W-1:0] post_bias_q;

  assign sum_ext = ACC_W'($signed(tree_sum));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      acc_q       <= '0;
      post_vld_q  <= 1'b0;
      post_ch_q   <= '0;
      post_bias_q <= '0;
    end else begin
      post_vld_q <= tag_vld_q[L] && tag_last_q[L];
      if (tag_vld_q[L]) acc_q <= tag_first_q[L] ? sum_ext : acc_q + sum_ext;
      if (tag_vld_q[L] && tag_last_q[L]) begin
        post_ch_q   <= tag_ch_q[L];
        post_bias_q <= bias_pipe_q[L-1];
      end
    end
  end

  // acc_q still holds the finished channel here, even if the next channel starts accumulating.
  logic signed [63:0] t_full;
  logic [DATA_W-1:0]  rq_dat;

  assign t_full = 64'(acc_q) + (64'(post_bias_q) <<< BIAS_SHIFT);
  assign rq_dat = DATA_W'(requant(t_full, OUT_SHIFT, DATA_W, relu_q));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
    end else begin
      wr_vld_q <= post_vld_q;
      if (post_vld_q) begin
        wr_addr_q <= post_ch_q;
        wr_dat_q  <= rq_dat;
      end
    end
  end

  assign bus.fc_output_wren = wr_vld_q;
  assign bus.fc_output_addr = wr_addr_q;
  assign bus.fc_output_data = wr_dat_q;

endmodule
